serial_byte_subtractor: RTL and testbench

//  Bit-serial subtractor: computes diff = x - y - borrow_in over WIDTH/BITS_PER_CYCLE cycles.

---
 rtl/serial_sub_pkg.sv | 28 ++
 rtl/full_subtractor.sv | 25 ++
 rtl/serial_byte_subtractor.sv | 202 ++++++++++++++++++++
 tb/tb_serial_byte_subtractor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub_pkg
// Purpose : Shared types and constants for the bit-serial subtractor.
//           Provides the controller state enum, default geometry and a helper
//           that sizes the step counter (never narrower than one bit).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

  localparam int SUB_DEFAULT_WIDTH = 8;
  localparam int SUB_DEFAULT_BPC   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Step counter width: $clog2(steps), with a floor of 1 so a single-step
  // configuration still has a legal counter.
  function automatic int sub_cnt_width(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor
// Purpose : One-bit full subtractor slice, d = a - b - bi.
// Ports   : a   in  minuend bit
//           b   in  subtrahend bit
//           bi  in  borrow in
//           d   out difference bit
//           bo  out borrow out
// Rev     : 1.0  initial release
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_byte_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_byte_subtractor
// Purpose : Bit-serial subtractor computing diff = x - y - borrow_in over
//           WIDTH/BITS_PER_CYCLE RUN cycles, with valid/ready handshakes on
//           both sides. borrow_out allows chaining multi-word subtracts.
// Config  : SUB_OVF_FLAG_EN - when defined, adds the ovf port (signed
//           overflow of the captured operands, valid with out_valid).
// Ports   : clk        in   rising-edge clock
//           rst_n      in   asynchronous active-low reset
//           in_valid   in   x / y / borrow_in valid
//           in_ready   out  operands accepted (IDLE only)
//           x          in   minuend      [WIDTH]
//           y          in   subtrahend   [WIDTH]
//           borrow_in  in   borrow into the LSB
//           out_valid  out  result valid (DONE only)
//           out_ready  in   consumer accepts result
//           diff       out  x - y - borrow_in mod 2**WIDTH
//           borrow_out out  unsigned x < y + borrow_in
//           ovf        out  signed overflow (SUB_OVF_FLAG_EN only)
// Rev     : 1.0  initial release
// ============================================================================
module serial_byte_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH          = SUB_DEFAULT_WIDTH,
  parameter int BITS_PER_CYCLE = SUB_DEFAULT_BPC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_FLAG_EN
  output logic             borrow_out,
  output logic             ovf
`else
  output logic             borrow_out
`endif
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = sub_cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  generate
    if ((BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
      $error("serial_byte_subtractor: BITS_PER_CYCLE (%0d) must divide WIDTH (%0d)",
             BITS_PER_CYCLE, WIDTH);
    end
  endgenerate

  sub_state_e             state_q, state_d;
  logic [WIDTH-1:0]       x_q, x_d;
  logic [WIDTH-1:0]       y_q, y_d;
  logic [WIDTH-1:0]       diff_q, diff_d;
  logic                   borrow_q, borrow_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // Holds in_ready low until the first clock after reset release.
  logic                   ready_en_q, ready_en_d;

  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic [BITS_PER_CYCLE:0]   borrow_chain;
  logic [WIDTH-1:0]          diff_shift;

  // --------------------------------------------------------------------------
  // Datapath: BITS_PER_CYCLE slices consume the low bits of the operand shift
  // registers, rippling the borrow from the registered carry-in upward.
  // --------------------------------------------------------------------------
  assign borrow_chain[0] = borrow_q;

  generate
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
      full_subtractor u_fs (
        .a  (x_q[i]),
        .b  (y_q[i]),
        .bi (borrow_chain[i]),
        .d  (slice_d[i]),
        .bo (borrow_chain[i+1])
      );
    end
  endgenerate

  // New result bits enter from the MSB side so that after the last step the
  // first-computed bits have migrated down to the LSB end.
  generate
    if (BITS_PER_CYCLE == WIDTH) begin : g_diff_whole
      assign diff_shift = slice_d;
    end else begin : g_diff_shift
      assign diff_shift = {slice_d, diff_q[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    cnt_d      = cnt_q;
    ready_en_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_d      = x;
          y_d      = y;
          borrow_d = borrow_in;
          diff_d   = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        x_d      = x_q >> BITS_PER_CYCLE;
        y_d      = y_q >> BITS_PER_CYCLE;
        borrow_d = borrow_chain[BITS_PER_CYCLE];
        diff_d   = diff_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      cnt_q      <= cnt_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Result outputs are forced to zero outside DONE so partial shift-register
  // contents never leak to the consumer.
  assign in_ready   = (state_q == IDLE) && ready_en_q;
  assign out_valid  = (state_q == DONE);
  assign diff       = out_valid ? diff_q : '0;
  assign borrow_out = out_valid & borrow_q;

`ifdef SUB_OVF_FLAG_EN
  // The operand shift registers are consumed during RUN, so the sign bits
  // are kept separately at capture time.
  logic x_msb_q, x_msb_d;
  logic y_msb_q, y_msb_d;

  always_comb begin
    x_msb_d = x_msb_q;
    y_msb_d = y_msb_q;
    if ((state_q == IDLE) && in_valid && in_ready) begin
      x_msb_d = x[WIDTH-1];
      y_msb_d = y[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_msb_q <= 1'b0;
      y_msb_q <= 1'b0;
    end else begin
      x_msb_q <= x_msb_d;
      y_msb_q <= y_msb_d;
    end
  end

  // Overflow only possible when operand signs differ and the result sign
  // disagrees with the minuend.
  assign ovf = out_valid && (x_msb_q != y_msb_q) && (diff_q[WIDTH-1] != x_msb_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_byte_subtractor
// Purpose : Self-checking bench for serial_byte_subtractor. Drives a default
//           (1 bit/cycle) instance and an 8 bits/cycle instance, compares
//           against an arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_byte_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in_valid = 1'b0;
  logic       b_in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       bin = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       sel = 1'b0;

  logic       a_in_ready, a_out_valid, a_bout, a_ovf;
  logic [7:0] a_diff;
  logic       b_in_ready, b_out_valid, b_bout, b_ovf;
  logic [7:0] b_diff;

  logic       m_in_ready, m_out_valid, m_bout, m_ovf;
  logic [7:0] m_diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_byte_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .x          (x),
    .y          (y),
    .borrow_in  (bin),
    .out_valid  (a_out_valid),
    .out_ready  (out_ready),
    .diff       (a_diff),
`ifdef SUB_OVF_FLAG_EN
    .borrow_out (a_bout),
    .ovf        (a_ovf)
`else
    .borrow_out (a_bout)
`endif
  );

  serial_byte_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_dut_bpc8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .x          (x),
    .y          (y),
    .borrow_in  (bin),
    .out_valid  (b_out_valid),
    .out_ready  (out_ready),
    .diff       (b_diff),
`ifdef SUB_OVF_FLAG_EN
    .borrow_out (b_bout),
    .ovf        (b_ovf)
`else
    .borrow_out (b_bout)
`endif
  );

`ifndef SUB_OVF_FLAG_EN
  assign a_ovf = 1'b0;
  assign b_ovf = 1'b0;
`endif

  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_diff      = sel ? b_diff      : a_diff;
  assign m_bout      = sel ? b_bout      : a_bout;
  assign m_ovf       = sel ? b_ovf       : a_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, borrow_out, diff} from plain integer arithmetic.
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b, input logic c);
    int ua, ub, s, sa, sb;
    logic [7:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    s  = ua - ub - int'(c);
    bo = (s < 0);
    d  = 8'((s + 256) % 256);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa - sb - int'(c);
    ov = (s > 127) || (s < -128);
    return {ov, bo, d};
  endfunction

  task automatic set_valid(input logic v);
    if (sel) b_in_valid = v;
    else     a_in_valid = v;
  endtask

  // One full transaction on the selected instance, with `stall` cycles of
  // out_ready low in DONE while junk in_valid is offered.
  task automatic run_op(input logic [7:0] xx, input logic [7:0] yy, input logic bb,
                        input int stall);
    logic [9:0] e;
    int lat;
    bit ok;
    e = ref_sub(xx, yy, bb);
    @(negedge clk);
    x = xx; y = yy; bin = bb; out_ready = 1'b0;
    set_valid(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("in_ready_timeout", 32'd0, 32'd1);
      set_valid(1'b0);
      return;
    end
    @(posedge clk);           // handshake edge counts as cycle 1
    lat = 1;
    @(negedge clk);
    set_valid(1'b0);
    // Operand changes after capture must not affect the result.
    x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
    while (!m_out_valid && lat < 30) begin
      set_valid(1'($urandom));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, sel ? 32'd2 : 32'd9);
    if (!m_out_valid) begin
      set_valid(1'b0);
      return;
    end
    check("diff", m_diff, e[7:0]);
    check("borrow_out", m_bout, e[8]);
`ifdef SUB_OVF_FLAG_EN
    check("ovf", m_ovf, e[9]);
`endif
    check("done_in_ready", m_in_ready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      set_valid(1'($urandom));
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", m_out_valid, 1'b1);
      check("hold_diff", {m_ovf, m_bout, m_diff}, {m_ovf & e[9], e[8], e[7:0]});
      check("hold_in_ready", m_in_ready, 1'b0);
    end
    // in_valid asserted alongside out_ready: must not be accepted in DONE.
    out_ready = 1'b1;
    set_valid(1'b1);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    set_valid(1'b0);
    check("release_out_valid", m_out_valid, 1'b0);
    check("release_in_ready", m_in_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_diff", a_diff, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_valid_after", a_out_valid, 1'b0);
    check("rst_bout", a_bout, 1'b0);
    check("rst_ovf", a_ovf, 1'b0);

    // Directed cases.
    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h0F, 1'b1, 0);
    run_op(8'h05, 8'h03, 1'b0, 5);

    // Reset in the middle of RUN.
    @(negedge clk);
    x = 8'hA5; y = 8'h5A; bin = 1'b0;
    a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    check("pre_rst_busy", a_in_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", a_out_valid, 1'b0);
    check("midrst_diff", a_diff, 8'h00);
    check("midrst_bout", a_bout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", a_in_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_result", a_out_valid, 1'b0);
    end
    run_op(8'h3C, 8'hC3, 1'b0, 1);

    // Full-width slice configuration: one RUN cycle.
    sel = 1'b1;
    run_op(8'h3C, 8'hC3, 1'b0, 2);
    for (int i = 0; i < 40; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    sel = 1'b0;

    // Randomized traffic on the serial instance.
    for (int i = 0; i < 2500; i++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
